mem_backing_store: RTL and testbench

- Behavioural main-memory responder: the memory side of the cache controller's refill/write-back interface.
- Accepts block-granular burst requests: refill reads, and dirty write-backs on eviction.
- Answers after a programmable access latency.
- Never-written words read back as their own byte address, so cache benches can check refill data without preloading.

---
 rtl/mem_backing_store.sv | 203 ++++++++++++++++++++
 tb/tb_mem_backing_store.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_backing_store.sv
// Behavioural main-memory responder for cache refill / write-back bursts; unwritten words read as their byte address.
// Optional MEM_STATS_EN adds saturating read-burst, write-burst and write-stall counters.
module mem_backing_store #(
  parameter int WORDS_PER_BLOCK = 4,
  parameter int LATENCY         = 3,
  parameter int AW              = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  output logic        mem_ack,
  input  logic [31:0] mem_wdata,
  input  logic        mem_wvalid,
  output logic        mem_wready,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        mem_done,
`ifdef MEM_STATS_EN
  output logic [15:0] stat_rd_bursts,
  output logic [15:0] stat_wr_bursts,
  output logic [15:0] stat_wr_stalls,
`endif
  output logic        busy
);

  localparam int DEPTH    = 1 << AW;
  localparam int OFF_BITS = $clog2(WORDS_PER_BLOCK * 4);
  localparam int BEAT_W   = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam int LAT_W    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY);
  localparam logic [31:0]       OFF_MASK  = 32'((WORDS_PER_BLOCK * 4) - 1);

  typedef enum logic [2:0] {
    IDLE,
    LAT,
    RBURST,
    WBURST,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]       base_q, base_d;
  logic              we_q, we_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              store_en;

  logic [DEPTH-1:0]  written_q;
  logic [31:0]       mem [DEPTH];

  logic [31:0]       rd_addr;
  logic [AW-1:0]     rd_idx;
  logic [31:0]       rd_word;
  logic [AW-1:0]     wr_idx;

  logic              ack_d, rvalid_d, wready_d, done_d, busy_d;
  logic [31:0]       rdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      we_q    <= 1'b0;
      lat_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      we_q    <= we_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
    end
  end

  // The ack cycle is always spent in LAT, so LATENCY=0 still leaves one idle cycle before the first beat.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    we_d     = we_q;
    lat_d    = lat_q;
    beat_d   = beat_q;
    store_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          state_d = LAT;
          base_d  = mem_addr & ~OFF_MASK;
          we_d    = mem_we;
          lat_d   = LAT_LOAD;
          beat_d  = '0;
        end
      end
      LAT: begin
        if (lat_q == '0) begin
          state_d = we_q ? WBURST : RBURST;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RBURST: begin
        if (beat_q == LAST_BEAT) begin
          state_d = DONE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      WBURST: begin
        if (mem_wvalid) begin
          store_en = 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read data is looked up for the beat about to be presented, so it lands in the output register with rvalid.
  always_comb begin
    rd_addr = base_q + {{(30 - BEAT_W){1'b0}}, beat_d, 2'b00};
    rd_idx  = rd_addr[AW+1:2];
    rd_word = written_q[rd_idx] ? mem[rd_idx] : rd_addr;
    wr_idx  = base_q[AW+1:2] + AW'(beat_q);
  end

  always_comb begin
    ack_d    = (state_q == IDLE) && mem_req;
    rvalid_d = (state_d == RBURST);
    wready_d = (state_d == WBURST);
    done_d   = (state_d == DONE);
    busy_d   = (state_d != IDLE);
    rdata_d  = rvalid_d ? rd_word : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ack    <= 1'b0;
      mem_rvalid <= 1'b0;
      mem_wready <= 1'b0;
      mem_done   <= 1'b0;
      busy       <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      mem_ack    <= ack_d;
      mem_rvalid <= rvalid_d;
      mem_wready <= wready_d;
      mem_done   <= done_d;
      busy       <= busy_d;
      mem_rdata  <= rdata_d;
    end
  end

  // Flags are cleared on reset but the data array is not, so a reset block reads back as addresses again.
  always_ff @(posedge clk) begin
    if (rst) begin
      written_q <= '0;
    end else if (store_en) begin
      written_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (store_en && !rst) begin
      mem[wr_idx] <= mem_wdata;
    end
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_bursts <= '0;
      stat_wr_bursts <= '0;
      stat_wr_stalls <= '0;
    end else begin
      if (state_d == DONE && !we_q && stat_rd_bursts != 16'hFFFF) begin
        stat_rd_bursts <= stat_rd_bursts + 16'd1;
      end
      if (state_d == DONE && we_q && stat_wr_bursts != 16'hFFFF) begin
        stat_wr_bursts <= stat_wr_bursts + 16'd1;
      end
      if (state_q == WBURST && !mem_wvalid && stat_wr_stalls != 16'hFFFF) begin
        stat_wr_stalls <= stat_wr_stalls + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_backing_store.sv
// Bench for mem_backing_store: per-cycle expectation table filled from burst timing rules plus literal pins.
// Instance 0 uses defaults (LATENCY=3, 4 beats); instance 1 uses LATENCY=0, 1 beat.
module tb_mem_backing_store;

  localparam int AW   = 16;
  localparam int L0   = 3;
  localparam int W0   = 4;
  localparam int L1   = 0;
  localparam int W1   = 1;
  localparam int NCYC = 512;

  localparam int SIG_ACK    = 0;
  localparam int SIG_RVALID = 1;
  localparam int SIG_WREADY = 2;
  localparam int SIG_DONE   = 3;
  localparam int SIG_BUSY   = 4;
  localparam int SIG_RDATA  = 5;
  localparam int SIG_STRD   = 6;
  localparam int SIG_STWR   = 7;
  localparam int SIG_STST   = 8;

  typedef struct packed {
    logic        ack;
    logic        rvalid;
    logic        wready;
    logic        done;
    logic        busy;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_tab [2][NCYC];

  logic        clk;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  logic        rst0, req0, we0, wvalid0;
  logic [31:0] addr0, wdata0;
  logic        ack0, wready0, rvalid0, done0, busy0;
  logic [31:0] rdata0;
  logic        rst1, req1, we1, wvalid1;
  logic [31:0] addr1, wdata1;
  logic        ack1, wready1, rvalid1, done1, busy1;
  logic [31:0] rdata1;
`ifdef MEM_STATS_EN
  logic [15:0] st_rd0, st_wr0, st_st0, st_rd1, st_wr1, st_st1;
`endif

  logic [31:0] mdl [int unsigned];
  int          exp_rd = 0;
  int          exp_wr = 0;
  int          exp_st = 0;

  int          lit_d [$];
  int          lit_c [$];
  int          lit_s [$];
  logic [31:0] lit_v [$];
  string       lit_n [$];

  mem_backing_store #(.WORDS_PER_BLOCK(W0), .LATENCY(L0), .AW(AW)) dut0 (
    .clk(clk), .rst(rst0), .mem_req(req0), .mem_we(we0), .mem_addr(addr0),
    .mem_ack(ack0), .mem_wdata(wdata0), .mem_wvalid(wvalid0), .mem_wready(wready0),
    .mem_rdata(rdata0), .mem_rvalid(rvalid0), .mem_done(done0),
`ifdef MEM_STATS_EN
    .stat_rd_bursts(st_rd0), .stat_wr_bursts(st_wr0), .stat_wr_stalls(st_st0),
`endif
    .busy(busy0)
  );

  mem_backing_store #(.WORDS_PER_BLOCK(W1), .LATENCY(L1), .AW(AW)) dut1 (
    .clk(clk), .rst(rst1), .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
    .mem_ack(ack1), .mem_wdata(wdata1), .mem_wvalid(wvalid1), .mem_wready(wready1),
    .mem_rdata(rdata1), .mem_rvalid(rvalid1), .mem_done(done1),
`ifdef MEM_STATS_EN
    .stat_rd_bursts(st_rd1), .stat_wr_bursts(st_wr1), .stat_wr_stalls(st_st1),
`endif
    .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(int d, int s);
    case (s)
      SIG_ACK:    return (d == 0) ? 32'(ack0) : 32'(ack1);
      SIG_RVALID: return (d == 0) ? 32'(rvalid0) : 32'(rvalid1);
      SIG_WREADY: return (d == 0) ? 32'(wready0) : 32'(wready1);
      SIG_DONE:   return (d == 0) ? 32'(done0) : 32'(done1);
      SIG_BUSY:   return (d == 0) ? 32'(busy0) : 32'(busy1);
      SIG_RDATA:  return (d == 0) ? rdata0 : rdata1;
`ifdef MEM_STATS_EN
      SIG_STRD:   return (d == 0) ? 32'(st_rd0) : 32'(st_rd1);
      SIG_STWR:   return (d == 0) ? 32'(st_wr0) : 32'(st_wr1);
      SIG_STST:   return (d == 0) ? 32'(st_st0) : 32'(st_st1);
`endif
      default:    return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Model memory: only written words are present; anything else reads as its own byte address.
  function automatic logic [31:0] model_word(int d, logic [31:0] a);
    int unsigned idx;
    idx = (a >> 2) & ((32'd1 << AW) - 32'd1);
    if (d == 0 && mdl.exists(idx)) return mdl[idx];
    return a;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic push_lit(int d, int c, int s, logic [31:0] v, string n);
    lit_d.push_back(d);
    lit_c.push_back(c);
    lit_s.push_back(s);
    lit_v.push_back(v);
    lit_n.push_back(n);
  endtask

  task automatic goto_cycle(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NCYC) begin
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("d%0d_ack@%0d", d, cyc), actual(d, SIG_ACK), 32'(exp_tab[d][cyc].ack));
        checkOutput($sformatf("d%0d_rvalid@%0d", d, cyc), actual(d, SIG_RVALID), 32'(exp_tab[d][cyc].rvalid));
        checkOutput($sformatf("d%0d_wready@%0d", d, cyc), actual(d, SIG_WREADY), 32'(exp_tab[d][cyc].wready));
        checkOutput($sformatf("d%0d_done@%0d", d, cyc), actual(d, SIG_DONE), 32'(exp_tab[d][cyc].done));
        checkOutput($sformatf("d%0d_busy@%0d", d, cyc), actual(d, SIG_BUSY), 32'(exp_tab[d][cyc].busy));
        if (exp_tab[d][cyc].rvalid)
          checkOutput($sformatf("d%0d_rdata@%0d", d, cyc), actual(d, SIG_RDATA), exp_tab[d][cyc].rdata);
      end
    end
    for (int i = 0; i < lit_c.size(); i++)
      if (lit_c[i] == cyc) checkOutput(lit_n[i], actual(lit_d[i], lit_s[i]), lit_v[i]);
  end

  // Read: ack one cycle after the request edge, beats after 1+LATENCY cycles, done right after the last beat.
  task automatic read_burst(int d, logic [31:0] a);
    int          c = cyc;
    int          lat = (d == 0) ? L0 : L1;
    int          w = (d == 0) ? W0 : W1;
    logic [31:0] base = a & ~32'(w * 4 - 1);
    exp_tab[d][c+1].ack = 1'b1;
    for (int k = c + 1; k <= c + 2 + lat + w; k++) exp_tab[d][k].busy = 1'b1;
    for (int i = 0; i < w; i++) begin
      exp_tab[d][c+2+lat+i].rvalid = 1'b1;
      exp_tab[d][c+2+lat+i].rdata  = model_word(d, base + 32'(4 * i));
    end
    exp_tab[d][c+2+lat+w].done = 1'b1;
    if (d == 0) exp_rd++;
    if (d == 0) begin req0 = 1'b1; we0 = 1'b0; addr0 = a; end
    else begin req1 = 1'b1; we1 = 1'b0; addr1 = a; end
    goto_cycle(c + 1);
    if (d == 0) req0 = 1'b0; else req1 = 1'b0;
    goto_cycle(c + 3 + lat + w);
  endtask

  // Write on instance 0 with an optional stall run and an optional reset after abort_after accepted beats.
  task automatic write_burst(logic [31:0] a, logic [31:0] d0, int stall_at, int stall_len,
                             bit junk, int abort_after);
    int          c = cyc;
    int          s = c + 2 + L0;
    int          b = 0;
    int          stalled = 0;
    int          k;
    logic [31:0] base = a & ~32'(W0 * 4 - 1);
    exp_tab[0][c+1].ack = 1'b1;
    for (int j = c + 1; j < s; j++) exp_tab[0][j].busy = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = a;
    goto_cycle(c + 1);
    req0 = 1'b0; we0 = 1'b0;
    if (junk) begin wvalid0 = 1'b1; wdata0 = 32'hDEAD_0000; end
    k = s;
    while (b < W0) begin
      goto_cycle(k);
      exp_tab[0][k].busy   = 1'b1;
      exp_tab[0][k].wready = 1'b1;
      if (abort_after > 0 && b == abort_after) begin
        wvalid0 = 1'b0;
        rst0    = 1'b1;
        push_lit(0, k + 1, SIG_BUSY, 32'd0, "rst_busy");
        push_lit(0, k + 1, SIG_WREADY, 32'd0, "rst_wready");
`ifdef MEM_STATS_EN
        push_lit(0, k + 1, SIG_STRD, 32'd0, "rst_stat_rd");
`endif
        goto_cycle(k + 1);
        rst0 = 1'b0;
        mdl.delete();
        exp_rd = 0; exp_wr = 0; exp_st = 0;
        goto_cycle(k + 2);
        return;
      end
      if (b == stall_at && stalled < stall_len) begin
        wvalid0 = 1'b0;
        wdata0  = 32'h0BAD_0BAD;
        stalled++;
        exp_st++;
      end else begin
        wvalid0 = 1'b1;
        wdata0  = d0 + 32'(b);
        mdl[((base >> 2) + 32'(b)) & ((32'd1 << AW) - 32'd1)] = d0 + 32'(b);
        b++;
      end
      k++;
    end
    goto_cycle(k);
    wvalid0 = 1'b0;
    exp_tab[0][k].busy = 1'b1;
    exp_tab[0][k].done = 1'b1;
    exp_wr++;
    goto_cycle(k + 1);
  endtask

  task automatic applyStimulus(int t);
    int c = cyc;
    case (t)
      0: begin
        push_lit(0, c + 1, SIG_ACK, 32'd1, "unwr_ack");
        push_lit(0, c + 4, SIG_RVALID, 32'd0, "unwr_no_early_beat");
        push_lit(0, c + 5, SIG_RDATA, 32'h8000_0040, "unwr_beat0");
        push_lit(0, c + 8, SIG_RDATA, 32'h8000_004C, "unwr_beat3");
        push_lit(0, c + 9, SIG_DONE, 32'd1, "unwr_done");
        push_lit(0, c + 10, SIG_BUSY, 32'd0, "unwr_idle");
        read_burst(0, 32'h8000_0040);
      end
      1: begin
        write_burst(32'h8000_4000, 32'h1111_0000, 99, 0, 1'b0, 2);
        c = cyc;
        push_lit(0, c + 5, SIG_RDATA, 32'h8000_4000, "rst_rd_beat0");
        push_lit(0, c + 6, SIG_RDATA, 32'h8000_4004, "rst_rd_beat1");
        read_burst(0, 32'h8000_4000);
      end
      2: begin
        push_lit(0, c + 9, SIG_DONE, 32'd0, "stall_not_done_early");
        push_lit(0, c + 12, SIG_DONE, 32'd1, "stall_done");
        write_burst(32'h8000_A000, 32'h5A5A_0000, 2, 3, 1'b0, 0);
`ifdef MEM_STATS_EN
        push_lit(0, cyc, SIG_STWR, 32'd1, "stat_wr_bursts");
        push_lit(0, cyc, SIG_STST, 32'd3, "stat_wr_stalls");
        push_lit(0, cyc, SIG_STRD, 32'd1, "stat_rd_bursts");
`endif
        c = cyc;
        push_lit(0, c + 7, SIG_RDATA, 32'h5A5A_0002, "stall_rd_beat2");
        read_burst(0, 32'h8000_A004);
      end
      3: begin
        write_burst(32'h8000_2000, 32'hCAFE_0001, 99, 0, 1'b1, 0);
        c = cyc;
        push_lit(0, c + 5, SIG_RDATA, 32'hCAFE_0001, "refill_beat0");
        push_lit(0, c + 8, SIG_RDATA, 32'hCAFE_0004, "refill_beat3");
        read_burst(0, 32'h8000_2008);
      end
      4: begin
        int c2 = c + L0 + W0 + 3;
        for (int r = 0; r < 2; r++) begin
          int cc = (r == 0) ? c : c2;
          exp_tab[0][cc+1].ack = 1'b1;
          for (int k = cc + 1; k <= cc + 2 + L0 + W0; k++) exp_tab[0][k].busy = 1'b1;
          for (int i = 0; i < W0; i++) begin
            exp_tab[0][cc+2+L0+i].rvalid = 1'b1;
            exp_tab[0][cc+2+L0+i].rdata  = model_word(0, 32'h8000_2000 + 32'(4 * i));
          end
          exp_tab[0][cc+2+L0+W0].done = 1'b1;
          exp_rd++;
        end
        push_lit(0, c + 9, SIG_BUSY, 32'd1, "held_busy_done");
        push_lit(0, c + 10, SIG_BUSY, 32'd0, "held_busy_gap");
        push_lit(0, c + 11, SIG_ACK, 32'd1, "held_second_ack");
        push_lit(0, c + 11, SIG_BUSY, 32'd1, "held_busy_again");
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h8000_2000;
        goto_cycle(c + 20);
        req0 = 1'b0;
        goto_cycle(c2 + L0 + W0 + 3);
      end
      5: begin
        push_lit(1, c + 1, SIG_ACK, 32'd1, "lat0_ack");
        push_lit(1, c + 1, SIG_RVALID, 32'd0, "lat0_no_beat_in_ack");
        push_lit(1, c + 2, SIG_RVALID, 32'd1, "lat0_rvalid");
        push_lit(1, c + 2, SIG_RDATA, 32'h8000_0010, "lat0_rdata");
        push_lit(1, c + 3, SIG_DONE, 32'd1, "lat0_done");
        push_lit(1, c + 4, SIG_BUSY, 32'd0, "lat0_idle");
        read_burst(1, 32'h8000_0010);
      end
      default: ;
    endcase
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NCYC; k++) exp_tab[d][k] = '0;
    rst0 = 1'b1; req0 = 1'b0; we0 = 1'b0; wvalid0 = 1'b0; addr0 = '0; wdata0 = '0;
    rst1 = 1'b1; req1 = 1'b0; we1 = 1'b0; wvalid1 = 1'b0; addr1 = '0; wdata1 = '0;
    goto_cycle(2);
    rst0 = 1'b0;
    rst1 = 1'b0;
    goto_cycle(4);
    for (int t = 0; t < 6; t++) applyStimulus(t);
    goto_cycle(cyc + 3);
`ifdef MEM_STATS_EN
    checkOutput("stat_rd_final", actual(0, SIG_STRD), 32'(exp_rd));
    checkOutput("stat_wr_final", actual(0, SIG_STWR), 32'(exp_wr));
    checkOutput("stat_st_final", actual(0, SIG_STST), 32'(exp_st));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
